// File: rtl/btn_dir_ctrl.sv
// Pushbutton front end for the snake game: synchronizes and debounces the five
// board buttons, then derives press pulses, a guarded heading and a pause flag.
module btn_dir_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic       tick,
    output logic [4:0] press,
    output logic [1:0] dir,
    output logic       dir_chg,
    output logic [1:0] cur_dir,
    output logic       pause
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [1:0]       DIR_RIGHT = 2'b01;

    logic [4:0]       sync_p0;
    logic [4:0]       sync_p1;
    logic [4:0]       deb;
    logic [4:0]       deb_q;
    logic [CNT_W-1:0] cnt [5];
    logic [1:0]       cand;
    logic             cand_vld;
    logic             accept;

    // U > R > D > L; bit index doubles as the heading encoding.
    function automatic logic [1:0] pick_dir(input logic [3:0] p);
        logic [1:0] d;
        d = 2'b00;
        if (p[0])      d = 2'b00;
        else if (p[1]) d = 2'b01;
        else if (p[2]) d = 2'b10;
        else if (p[3]) d = 2'b11;
        return d;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // A level is accepted only after the synced input has differed for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
            press <= '0;
        end else begin
            deb_q <= deb;
            press <= deb & ~deb_q;
        end
    end

    always_comb begin
        cand_vld = |press[3:0];
        cand     = pick_dir(press[3:0]);
        // Reversal is judged against the committed heading, not the pending request.
        accept   = cand_vld && (cand != (cur_dir ^ 2'b10)) && (cand != dir);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir     <= DIR_RIGHT;
            cur_dir <= DIR_RIGHT;
            dir_chg <= 1'b0;
            pause   <= 1'b0;
        end else begin
            dir_chg <= accept;
            if (accept)   dir     <= cand;
            if (tick)     cur_dir <= dir;
            if (press[4]) pause   <= ~pause;
        end
    end

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Directed bench for btn_dir_ctrl with a short debounce window (DEB_CYCLES=4).
module tb_btn_dir_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic       tick;
    logic [4:0] press;
    logic [1:0] dir;
    logic       dir_chg;
    logic [1:0] cur_dir;
    logic       pause;

    int vectors     = 0;
    int miscompares = 0;
    int press_cnt [5];
    int first_press [5];
    int chg_cnt;
    int cyc;

    btn_dir_ctrl #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn(btn), .tick(tick),
        .press(press), .dir(dir), .dir_chg(dir_chg),
        .cur_dir(cur_dir), .pause(pause)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (press[i] === 1'b1) begin
                press_cnt[i]++;
                if (first_press[i] < 0) first_press[i] = cyc;
            end
        end
        if (dir_chg === 1'b1) chg_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        cyc = 0;
        chg_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            press_cnt[i] = 0;
            first_press[i] = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn = 5'b0;
        tick = 1'b0;
        steps(3);
        rst = 1'b1;
        clear_mon();
    endtask

    task automatic tap(input logic [4:0] m);
        btn = m;
        steps(10);
        btn = 5'b0;
        steps(10);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn = 5'b11111;
        tick = 1'b0;
        clear_mon();
        steps(3);
        vectors++; if (press !== 5'b0) begin miscompares++; $display("FAIL rst_press: got %b want 00000", press); end
        vectors++; if (dir !== 2'b01) begin miscompares++; $display("FAIL rst_dir: got %b want 01", dir); end
        vectors++; if (cur_dir !== 2'b01) begin miscompares++; $display("FAIL rst_cur_dir: got %b want 01", cur_dir); end
        vectors++; if (pause !== 1'b0) begin miscompares++; $display("FAIL rst_pause: got %b want 0", pause); end
        vectors++; if (dir_chg !== 1'b0) begin miscompares++; $display("FAIL rst_dir_chg: got %b want 0", dir_chg); end
        vectors++; if (press_cnt[0] !== 0) begin miscompares++; $display("FAIL rst_no_press_held: got %0d want 0", press_cnt[0]); end
        rst = 1'b1;
        clear_mon();
        steps(12);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (press_cnt[i] !== 1) begin miscompares++; $display("FAIL rst_release_press%0d: got %0d pulses want 1", i, press_cnt[i]); end
        end
        vectors++; if (first_press[0] !== DEB + 3) begin miscompares++; $display("FAIL rst_release_latency: got %0d want %0d", first_press[0], DEB + 3); end
        vectors++; if (dir !== 2'b00) begin miscompares++; $display("FAIL rst_release_dir: got %b want 00", dir); end
        vectors++; if (chg_cnt !== 1) begin miscompares++; $display("FAIL rst_release_chg: got %0d want 1", chg_cnt); end
        vectors++; if (pause !== 1'b1) begin miscompares++; $display("FAIL rst_release_pause: got %b want 1", pause); end
        vectors++; if (cur_dir !== 2'b01) begin miscompares++; $display("FAIL rst_release_cur_dir: got %b want 01", cur_dir); end
        btn = 5'b0;
        steps(10);
        vectors++; if (press_cnt[4] !== 1) begin miscompares++; $display("FAIL rst_release_no_pulse: got %0d want 1", press_cnt[4]); end
    endtask

    task automatic test_debounce();
        do_reset();
        btn = 5'b00001;
        steps(3);
        btn = 5'b0;
        steps(10);
        vectors++; if (press_cnt[0] !== 0) begin miscompares++; $display("FAIL deb_glitch_press: got %0d want 0", press_cnt[0]); end
        vectors++; if (dir !== 2'b01) begin miscompares++; $display("FAIL deb_glitch_dir: got %b want 01", dir); end
        clear_mon();
        btn = 5'b00001;
        steps(30);
        vectors++; if (press_cnt[0] !== 1) begin miscompares++; $display("FAIL deb_held_press: got %0d want 1", press_cnt[0]); end
        vectors++; if (first_press[0] !== 7) begin miscompares++; $display("FAIL deb_latency: got %0d want 7", first_press[0]); end
        vectors++; if (dir !== 2'b00) begin miscompares++; $display("FAIL deb_dir: got %b want 00", dir); end
        vectors++; if (chg_cnt !== 1) begin miscompares++; $display("FAIL deb_chg: got %0d want 1", chg_cnt); end
        btn = 5'b0;
        steps(10);
        vectors++; if (press_cnt[0] !== 1) begin miscompares++; $display("FAIL deb_release: got %0d want 1", press_cnt[0]); end
    endtask

    task automatic test_anti_reversal();
        do_reset();
        tap(5'b01000);
        vectors++; if (press_cnt[3] !== 1) begin miscompares++; $display("FAIL ar_l_press: got %0d want 1", press_cnt[3]); end
        vectors++; if (dir !== 2'b01) begin miscompares++; $display("FAIL ar_l_dir: got %b want 01", dir); end
        vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL ar_l_chg: got %0d want 0", chg_cnt); end
        tap(5'b00001);
        vectors++; if (dir !== 2'b00) begin miscompares++; $display("FAIL ar_u_dir: got %b want 00", dir); end
        tap(5'b00100);
        vectors++; if (dir !== 2'b10) begin miscompares++; $display("FAIL ar_d_dir: got %b want 10", dir); end
        vectors++; if (chg_cnt !== 2) begin miscompares++; $display("FAIL ar_d_chg: got %0d want 2", chg_cnt); end
        vectors++; if (cur_dir !== 2'b01) begin miscompares++; $display("FAIL ar_cur_before_tick: got %b want 01", cur_dir); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        vectors++; if (cur_dir !== 2'b10) begin miscompares++; $display("FAIL ar_tick_commit: got %b want 10", cur_dir); end
        tap(5'b00001);
        vectors++; if (dir !== 2'b10) begin miscompares++; $display("FAIL ar_u_reject_dir: got %b want 10", dir); end
        vectors++; if (chg_cnt !== 2) begin miscompares++; $display("FAIL ar_u_reject_chg: got %0d want 2", chg_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tap(5'b01001);
        vectors++; if (dir !== 2'b00) begin miscompares++; $display("FAIL sim_dir: got %b want 00", dir); end
        vectors++; if (chg_cnt !== 1) begin miscompares++; $display("FAIL sim_chg: got %0d want 1", chg_cnt); end
        vectors++; if (press_cnt[3] !== 1) begin miscompares++; $display("FAIL sim_l_press: got %0d want 1", press_cnt[3]); end
    endtask

    task automatic test_tick_collision();
        bit found;
        do_reset();
        found = 1'b0;
        btn = 5'b00100;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (press[2] === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL tc_press_timeout: got none want press[2]"); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        vectors++; if (dir !== 2'b10) begin miscompares++; $display("FAIL tc_dir: got %b want 10", dir); end
        vectors++; if (cur_dir !== 2'b01) begin miscompares++; $display("FAIL tc_cur_old: got %b want 01", cur_dir); end
        vectors++; if (dir_chg !== 1'b1) begin miscompares++; $display("FAIL tc_dir_chg: got %b want 1", dir_chg); end
        btn = 5'b0;
        steps(10);
        tick = 1'b1;
        step();
        tick = 1'b0;
        vectors++; if (cur_dir !== 2'b10) begin miscompares++; $display("FAIL tc_cur_next: got %b want 10", cur_dir); end
    endtask

    task automatic test_pause();
        bit found;
        do_reset();
        tap(5'b10000);
        vectors++; if (pause !== 1'b1) begin miscompares++; $display("FAIL pause_first: got %b want 1", pause); end
        tap(5'b10000);
        vectors++; if (pause !== 1'b0) begin miscompares++; $display("FAIL pause_second: got %b want 0", pause); end
        vectors++; if (press_cnt[4] !== 2) begin miscompares++; $display("FAIL pause_press_cnt: got %0d want 2", press_cnt[4]); end
        found = 1'b0;
        btn = 5'b10001;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (press[4] === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL pause_c_timeout: got none want press[4]"); end
        step();
        vectors++; if (pause !== 1'b1) begin miscompares++; $display("FAIL pause_cu_pause: got %b want 1", pause); end
        vectors++; if (dir !== 2'b00) begin miscompares++; $display("FAIL pause_cu_dir: got %b want 00", dir); end
        vectors++; if (dir_chg !== 1'b1) begin miscompares++; $display("FAIL pause_cu_chg: got %b want 1", dir_chg); end
        btn = 5'b0;
        steps(10);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_anti_reversal();
        test_simultaneous();
        test_tick_collision();
        test_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
